// File: rtl/hazard_scoreboard_if.sv
// Decode/write-back interface of the hazard scoreboard.
// The master drives the ID issue fields and the WB retire strobe.
// The slave returns the stall request and the scoreboard status.
interface hazard_scoreboard_if #(
    parameter int NUM_REGS = 16
) ();
    localparam int IDX_W = $clog2(NUM_REGS);

    logic                id_valid;
    logic [IDX_W-1:0]    src1;
    logic [IDX_W-1:0]    src2;
    logic                two_src;
    logic [IDX_W-1:0]    id_dest;
    logic                id_wb_en;
    logic                flush;
    logic [IDX_W-1:0]    wb_dest;
    logic                wb_en;
    logic                hazard;
    logic [NUM_REGS-1:0] pending_mask;
    logic [15:0]         stall_cycles;
    logic                sb_err;

    modport master (
        output id_valid, src1, src2, two_src, id_dest, id_wb_en, flush, wb_dest, wb_en,
        input  hazard, pending_mask, stall_cycles, sb_err
    );

    modport slave (
        input  id_valid, src1, src2, two_src, id_dest, id_wb_en, flush, wb_dest, wb_en,
        output hazard, pending_mask, stall_cycles, sb_err
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register in-flight write tracker for the ID stage.
// Each architectural register owns a small counter of writes that have
// issued but not yet retired.  ID stalls while a source it reads is still
// pending.  ID also stalls while the destination counter is saturated.

// One register's in-flight counter.
// inc is the issue to this register, and dec is the retire of this register.
module hazard_scoreboard_cell #(
    parameter int CNT_W     = 2,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic busy,
    output logic full,
    output logic empty
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    // An issue and a retire on the same edge cancel out.  A retire at zero is held at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              cnt <= '0;
        else if (inc && !dec)                 cnt <= cnt + ONE;
        else if (dec && !inc && cnt != '0)    cnt <= cnt - ONE;
    end

    // The regfile writes on negedge, so the last pending write retiring this cycle is already readable.
    always_comb begin
        empty = (cnt == '0);
        full  = (cnt == '1);
        busy  = !empty && !(WB_BYPASS && dec && cnt == ONE);
    end
endmodule

module hazard_scoreboard #(
    parameter int NUM_REGS  = 16,
    parameter int CNT_W     = 2,
    parameter bit WB_BYPASS = 1'b1
) (
    input logic              clk,
    input logic              rst,
    hazard_scoreboard_if.slave sb
);
    localparam int IDX_W = $clog2(NUM_REGS);

    logic [NUM_REGS-1:0] busy_v;
    logic [NUM_REGS-1:0] full_v;
    logic [NUM_REGS-1:0] empty_v;
    logic [NUM_REGS-1:0] inc_v;
    logic [NUM_REGS-1:0] dec_v;
    logic                hazard;
    logic                issue;
    logic [15:0]         stall_cycles;
    logic                sb_err;

    // A flushed instruction neither stalls nor records an issue.  Its retire side is untouched.
    always_comb begin
        hazard = sb.id_valid && !sb.flush &&
                 (busy_v[sb.src1] ||
                  (sb.two_src && busy_v[sb.src2]) ||
                  (sb.id_wb_en && full_v[sb.id_dest]));
        issue  = sb.id_valid && sb.id_wb_en && !hazard && !sb.flush;
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_reg
            assign inc_v[g] = issue    && (sb.id_dest == IDX_W'(g));
            assign dec_v[g] = sb.wb_en && (sb.wb_dest == IDX_W'(g));

            hazard_scoreboard_cell #(
                .CNT_W     (CNT_W),
                .WB_BYPASS (WB_BYPASS)
            ) u_cell (
                .clk   (clk),
                .rst   (rst),
                .inc   (inc_v[g]),
                .dec   (dec_v[g]),
                .busy  (busy_v[g]),
                .full  (full_v[g]),
                .empty (empty_v[g])
            );
        end
    endgenerate

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               stall_cycles <= '0;
        else if (hazard && stall_cycles != '1) stall_cycles <= stall_cycles + 16'd1;
    end

    // Sticky flag for a retire with no write in flight, such as an orphan left over from before a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 sb_err <= 1'b0;
        else if (sb.wb_en && empty_v[sb.wb_dest]) sb_err <= 1'b1;
    end

    assign sb.hazard       = hazard;
    assign sb.pending_mask = ~empty_v;
    assign sb.stall_cycles = stall_cycles;
    assign sb.sb_err       = sb_err;
endmodule
